result_serializer: RTL

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/rah_calc_pkg.sv | 36 +++
 rtl/result_fifo.sv | 67 ++++++
 rtl/result_serializer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rah_calc_pkg.sv
// Shared types and constants for the result serializer: FSM state enum,
// byte width and per-frame byte-count helpers. Honours RESULT_SER_TAG_EN.
package rah_calc_pkg;

    localparam int BYTE_W = 8;

`ifdef RESULT_SER_TAG_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_TAG  = 2'd2,
        ST_SEND = 2'd3
    } ser_state_t;

    localparam int TAG_BYTES = 1;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd3
    } ser_state_t;

    localparam int TAG_BYTES = 0;
`endif

    // Payload bytes carried by one result word.
    function automatic int calc_nb(input int width);
        return width / BYTE_W;
    endfunction

    // Bytes on the wire per frame, including the optional tag byte.
    function automatic int calc_frame_len(input int width);
        return calc_nb(width) + TAG_BYTES;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous result-word FIFO with full/empty/count status.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout, full, empty, count.
module result_fifo
    import rah_calc_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push at full is still taken when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/result_serializer.sv
// Buffers calc-op result words and streams them MSB-first as bytes over a
// valid/ready port. Ports: clk, rst_n (sync, active-low), din/din_wren,
// out_data/out_valid/out_ready/out_last, overflow (sticky), fifo_count.
// Macro RESULT_SER_TAG_EN prefixes each frame with a sequence tag byte.
module result_serializer
    import rah_calc_pkg::*;
#(
    parameter int RAH_PACKET_WIDTH = 48,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RAH_PACKET_WIDTH-1:0]   din,
    input  logic                          din_wren,
    output logic [BYTE_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int W  = RAH_PACKET_WIDTH;
    localparam int NB = calc_nb(RAH_PACKET_WIDTH);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    logic                        fifo_full, fifo_empty, fifo_pop;
    logic [W-1:0]                fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    result_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (din_wren),
        .din   (din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    ser_state_t        state_q, state_d;
    logic [W-1:0]      sr_q, sr_d, sr_shift;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              overflow_q, overflow_d;
    logic              xfer;
`ifdef RESULT_SER_TAG_EN
    logic [7:0]        tag_q, tag_d;
`endif

    assign xfer     = out_valid_q & out_ready;
    assign sr_shift = sr_q << BYTE_W;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        fifo_pop    = 1'b0;
`ifdef RESULT_SER_TAG_EN
        tag_d       = tag_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop    = 1'b1;
                sr_d        = fifo_dout;
                idx_d       = '0;
                out_valid_d = 1'b1;
`ifdef RESULT_SER_TAG_EN
                state_d     = ST_TAG;
                out_data_d  = tag_q;
                out_last_d  = 1'b0;
`else
                state_d     = ST_SEND;
                out_data_d  = fifo_dout[W-1 -: BYTE_W];
                out_last_d  = (NB == 1);
`endif
            end
`ifdef RESULT_SER_TAG_EN
            ST_TAG: begin
                if (xfer) begin
                    state_d    = ST_SEND;
                    out_data_d = sr_q[W-1 -: BYTE_W];
                    out_last_d = (NB == 1);
                end
            end
`endif
            ST_SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
`ifdef RESULT_SER_TAG_EN
                        tag_d       = tag_q + 8'd1;
`endif
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        sr_d       = sr_shift;
                        out_data_d = sr_shift[W-1 -: BYTE_W];
                        out_last_d = ((idx_q + 1'b1) == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Only a write that cannot displace a popped head is lost.
        overflow_d = overflow_q | (din_wren & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef RESULT_SER_TAG_EN
            tag_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
`ifdef RESULT_SER_TAG_EN
            tag_q       <= tag_d;
`endif
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign overflow   = overflow_q;
    assign fifo_count = fifo_cnt;

endmodule
